// File: rtl/gf_pkg.sv
// Shared types and constants for the sequential GF(2^WIDTH) multiplier.
package gf_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} gf_state_e;

    localparam logic [7:0]  GF8_AES_POLY = 8'h1B;
    localparam logic [3:0]  GF4_POLY     = 4'h3;
    localparam logic [15:0] GF16_POLY    = 16'h002B;

    // Width of a counter that holds 0..w inclusive, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// One-step multiply-by-x modulo x^WIDTH + POLY; purely combinational.
module gf_xtime
    import gf_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF8_AES_POLY)
) (
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    end

endmodule

// File: rtl/gf_mult_seq.sv
// Bit-serial GF(2^WIDTH) multiplier: Horner evaluation over b, MSB first, one bit per clock,
// with valid/ready handshakes on both operand and product sides.
module gf_mult_seq
    import gf_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF8_AES_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    gf_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_x;
    logic [CW-1:0]    cnt_q;

    gf_xtime #(
        .WIDTH(WIDTH),
        .POLY (POLY)
    ) u_xtime (
        .v(acc_q),
        .y(acc_x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == BUSY);
        out_valid = (state_q == DONE);
        // Gate the accumulator so a partial product never reaches the output.
        product   = (state_q == DONE) ? acc_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= '0;
                        cnt_q <= CW'(WIDTH);
                    end
                end
                BUSY: begin
                    acc_q <= acc_x ^ (b_q[WIDTH-1] ? a_q : '0);
                    b_q   <= b_q << 1;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
